// File: rtl/dram_responder_pkg.sv
// rtl/dram_responder_pkg.sv - shared FSM encoding and bus width defaults for the DRAM path
package dram_responder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/dram_responder_if.sv
// rtl/dram_responder_if.sv - address-unit to DRAM request/response bus
interface dram_responder_if
  import dram_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-1:0] addr;
  logic              req;
  logic              we;
  logic [DATA_W-1:0] wrData;
  logic              busy;
  logic              done;
  logic              rdValid;
  logic [DATA_W-1:0] rdData;
  logic              err;

  modport master (
    output addr, req, we, wrData,
    input  busy, done, rdValid, rdData, err
  );

  modport slave (
    input  addr, req, we, wrData,
    output busy, done, rdValid, rdData, err
  );

endinterface

// File: rtl/dram_array.sv
// rtl/dram_array.sv - single-port synchronous RAM; read port only updates on reads
module dram_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  Clk1,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wrData,
  output logic [DATA_W-1:0]     rdData
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge Clk1) begin
    if (en) begin
      if (we) r_mem[addr] <= wrData;
      else    rdData      <= r_mem[addr];
    end
  end

endmodule

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - DRAM-side responder: one transaction in flight, fixed access latency
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 3
) (
  input  logic            Clk1,
  input  logic            Rst_n,
  dram_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [DEPTH_LOG2-1:0]   r_addr;
  logic                    r_we;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_done;
  logic                    r_rd_valid;
  logic                    r_err;
  logic                    r_have_rd;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_busy;
  logic                    w_arr_en;
  logic [DATA_W-1:0]       w_arr_rd;

  assign w_accept   = (r_state == ST_IDLE) && bus.req;
  assign w_in_range = ((bus.addr >> DEPTH_LOG2) == '0);

  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // WAIT is left on the cycle the counter would hit zero, so ACCESS ends exactly LATENCY edges after acceptance
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.req && w_in_range) w_next = (LATENCY == 1) ? ST_ACCESS : ST_WAIT;
      ST_WAIT:   if (r_cnt <= CNT_W'(1)) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != ST_IDLE);
    w_arr_en = (r_state == ST_ACCESS);
  end

  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_have_rd  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.addr[DEPTH_LOG2-1:0];
        r_we    <= bus.we;
        r_wdata <= bus.wrData;
        r_cnt   <= LAT_M1;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_err      <= w_accept && !w_in_range;
      r_done     <= (r_state == ST_ACCESS);
      r_rd_valid <= (r_state == ST_ACCESS) && !r_we;
      if ((r_state == ST_ACCESS) && !r_we) r_have_rd <= 1'b1;
    end
  end

  dram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .Clk1   (Clk1),
    .en     (w_arr_en),
    .we     (r_we),
    .addr   (r_addr),
    .wrData (r_wdata),
    .rdData (w_arr_rd)
  );

  // RAM output is unreset, so rdData reads as zero until the first completed read
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.rdValid = r_rd_valid;
  assign bus.err     = r_err;
  assign bus.rdData  = r_have_rd ? w_arr_rd : '0;

endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - directed self-checking bench for dram_responder (LATENCY 3 and 1 builds)
module tb_dram_responder;

  logic Clk1  = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk1 = ~Clk1;

  dram_responder_if #(.DATA_W(16), .ADDR_W(16)) b1 ();
  dram_responder_if #(.DATA_W(16), .ADDR_W(16)) b2 ();

  dram_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(3)) dut (
    .Clk1(Clk1), .Rst_n(Rst_n), .bus(b1.slave)
  );

  dram_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
    .Clk1(Clk1), .Rst_n(Rst_n), .bus(b2.slave)
  );

  task automatic step();
    @(posedge Clk1);
    #1;
  endtask

  task automatic drive(input bit sel, input logic rq, input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (sel) begin
      b2.req = rq; b2.we = wr; b2.addr = a; b2.wrData = d;
    end else begin
      b1.req = rq; b1.we = wr; b1.addr = a; b1.wrData = d;
    end
  endtask

  // presents one request for a single edge, returns edges until done (-1 on timeout)
  task automatic run_txn(input bit sel, input logic wr, input logic [15:0] a, input logic [15:0] d, output int lat);
    drive(sel, 1'b1, wr, a, d);
    step();
    drive(sel, 1'b0, 1'b0, a, d);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (sel ? b2.done : b1.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    drive(0, 0, 0, 16'h0, 16'h0);
    drive(1, 0, 0, 16'h0, 16'h0);
    #2;
    checks++; if (b1.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", b1.busy); end
    checks++; if (b1.done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b exp 0", b1.done); end
    checks++; if (b1.rdValid !== 1'b0)   begin errors++; $display("FAIL rst_rdvalid got %b exp 0", b1.rdValid); end
    checks++; if (b1.err !== 1'b0)       begin errors++; $display("FAIL rst_err got %b exp 0", b1.err); end
    checks++; if (b1.rdData !== 16'h0)   begin errors++; $display("FAIL rst_rddata got %h exp 0000", b1.rdData); end
    step(); step();
    Rst_n = 1'b1;
    step();
    run_txn(0, 1, 16'h0005, 16'h1111, lat);
    run_txn(0, 0, 16'h0005, 16'h0000, lat);
    checks++; if (b1.rdData !== 16'h1111) begin errors++; $display("FAIL pre_read got %h exp 1111", b1.rdData); end
    step();
    drive(0, 1, 1, 16'h0005, 16'h2222);
    step();
    drive(0, 0, 0, 16'h0005, 16'h0);
    step();
    checks++; if (b1.busy !== 1'b1)      begin errors++; $display("FAIL mid_wait_busy got %b exp 1", b1.busy); end
    Rst_n = 1'b0;
    #1;
    checks++; if (b1.busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b exp 0", b1.busy); end
    checks++; if (b1.done !== 1'b0)      begin errors++; $display("FAIL abort_done got %b exp 0", b1.done); end
    checks++; if (b1.rdData !== 16'h0)   begin errors++; $display("FAIL abort_rddata got %h exp 0000", b1.rdData); end
    step();
    Rst_n = 1'b1;
    step();
    run_txn(0, 0, 16'h0005, 16'h0000, lat);
    checks++; if (lat !== 3)              begin errors++; $display("FAIL post_rst_lat got %0d exp 3", lat); end
    checks++; if (b1.rdData !== 16'h1111) begin errors++; $display("FAIL aborted_write got %h exp 1111", b1.rdData); end
  endtask

  task automatic test_write_read();
    int lat;
    run_txn(0, 1, 16'h00A0, 16'hBEEF, lat);
    checks++; if (lat !== 3)              begin errors++; $display("FAIL wr_lat got %0d exp 3", lat); end
    checks++; if (b1.rdValid !== 1'b0)    begin errors++; $display("FAIL wr_rdvalid got %b exp 0", b1.rdValid); end
    checks++; if (b1.rdData !== 16'h1111) begin errors++; $display("FAIL wr_keeps_rddata got %h exp 1111", b1.rdData); end
    run_txn(0, 0, 16'h00A0, 16'h0000, lat);
    checks++; if (lat !== 3)              begin errors++; $display("FAIL rd_lat got %0d exp 3", lat); end
    checks++; if (b1.rdValid !== 1'b1)    begin errors++; $display("FAIL rd_rdvalid got %b exp 1", b1.rdValid); end
    checks++; if (b1.rdData !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h exp beef", b1.rdData); end
    checks++; if (b1.busy !== 1'b0)       begin errors++; $display("FAIL rd_busy_drop got %b exp 0", b1.busy); end
    step();
    checks++; if (b1.done !== 1'b0 || b1.rdValid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width got %b%b exp 00", b1.done, b1.rdValid); end
  endtask

  task automatic test_out_of_range();
    int nd = 0;
    drive(0, 1, 0, 16'h0400, 16'h0);
    step();
    drive(0, 0, 0, 16'h0400, 16'h0);
    checks++; if (b1.err !== 1'b1)  begin errors++; $display("FAIL oor_err got %b exp 1", b1.err); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL oor_busy got %b exp 0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL oor_done got %b exp 0", b1.done); end
    step();
    checks++; if (b1.err !== 1'b0)  begin errors++; $display("FAIL oor_err_pulse got %b exp 0", b1.err); end
    for (int k = 0; k < 6; k++) begin
      if (b1.done) nd++;
      step();
    end
    checks++; if (nd !== 0)              begin errors++; $display("FAIL oor_no_done got %0d exp 0", nd); end
    checks++; if (b1.rdData !== 16'hBEEF) begin errors++; $display("FAIL oor_rddata got %h exp beef", b1.rdData); end
  endtask

  task automatic test_busy_drop();
    int lat;
    int nd = 0;
    logic [15:0] rd = 16'h0;
    run_txn(0, 1, 16'h0010, 16'h0101, lat);
    run_txn(0, 1, 16'h0020, 16'h0202, lat);
    drive(0, 1, 0, 16'h0010, 16'h0);
    step();
    drive(0, 1, 0, 16'h0020, 16'h0);
    step();
    drive(0, 0, 0, 16'h0020, 16'h0);
    for (int k = 0; k < 10; k++) begin
      step();
      if (b1.done) begin nd++; rd = b1.rdData; end
    end
    checks++; if (nd !== 1)         begin errors++; $display("FAIL drop_done_count got %0d exp 1", nd); end
    checks++; if (rd !== 16'h0101)  begin errors++; $display("FAIL drop_rddata got %h exp 0101", rd); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int idx  = 1;
    int last = -1;
    for (int i = 1; i <= 4; i++) run_txn(0, 1, 16'(i), 16'hC000 | 16'(i), lat);
    drive(0, 1, 0, 16'h0001, 16'h0);
    for (int t = 1; t <= 40; t++) begin
      step();
      if (b1.done) begin
        checks++; if (b1.rdData !== (16'hC000 | 16'(idx))) begin errors++; $display("FAIL b2b_data idx %0d got %h exp %h", idx, b1.rdData, 16'hC000 | 16'(idx)); end
        if (last >= 0) begin
          checks++; if (t - last !== 4) begin errors++; $display("FAIL b2b_gap idx %0d got %0d exp 4", idx, t - last); end
        end
        last = t;
        idx++;
        if (idx > 4) begin
          drive(0, 0, 0, 16'h0, 16'h0);
          break;
        end
        drive(0, 1, 0, 16'(idx), 16'h0);
      end
    end
    drive(0, 0, 0, 16'h0, 16'h0);
    checks++; if (idx !== 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", idx); end
    step();
  endtask

  task automatic test_latency1();
    int lat;
    run_txn(1, 1, 16'h03FF, 16'h5A5A, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL l1_wr_lat got %0d exp 1", lat); end
    step();
    drive(1, 1, 0, 16'h03FF, 16'h0);
    step();
    drive(1, 0, 0, 16'h03FF, 16'h0);
    checks++; if (b2.busy !== 1'b1)       begin errors++; $display("FAIL l1_busy got %b exp 1", b2.busy); end
    checks++; if (b2.done !== 1'b0)       begin errors++; $display("FAIL l1_early_done got %b exp 0", b2.done); end
    step();
    checks++; if (b2.done !== 1'b1)       begin errors++; $display("FAIL l1_done got %b exp 1", b2.done); end
    checks++; if (b2.rdValid !== 1'b1)    begin errors++; $display("FAIL l1_rdvalid got %b exp 1", b2.rdValid); end
    checks++; if (b2.rdData !== 16'h5A5A) begin errors++; $display("FAIL l1_rddata got %h exp 5a5a", b2.rdData); end
    checks++; if (b2.busy !== 1'b0)       begin errors++; $display("FAIL l1_busy_drop got %b exp 0", b2.busy); end
    checks++; if (b2.err !== 1'b0)        begin errors++; $display("FAIL l1_err got %b exp 0", b2.err); end
    step();
    checks++; if (b2.done !== 1'b0 || b2.busy !== 1'b0) begin errors++; $display("FAIL l1_idle got done %b busy %b exp 0 0", b2.done, b2.busy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_busy_drop();
    test_back_to_back();
    test_latency1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
